// File: rtl/fetch_rob_if.sv
// Purpose: groups the fetch unit's memory request/response, decode delivery,
//          redirect and error signals into one bundle.
// Ports:   master = fetch unit side (drives requests, delivery, err);
//          slave  = environment side (memory, decode, redirect source).
interface fetch_rob_if #(
  parameter int P_ADDR_BITS = 32,
  parameter int P_INST_BITS = 32,
  parameter int P_OPAQ_BITS = 8
);
  logic                   mem_req_val;
  logic                   mem_req_rdy;
  logic [P_ADDR_BITS-1:0] mem_req_addr;
  logic [P_OPAQ_BITS-1:0] mem_req_opaque;
  logic                   mem_resp_val;
  logic                   mem_resp_rdy;
  logic [P_OPAQ_BITS-1:0] mem_resp_opaque;
  logic [P_INST_BITS-1:0] mem_resp_data;
  logic                   d_val;
  logic                   d_rdy;
  logic [P_INST_BITS-1:0] d_inst;
  logic [P_ADDR_BITS-1:0] d_pc;
  logic                   squash;
  logic [P_ADDR_BITS-1:0] branch_target;
  logic                   err;

  modport master (
    output mem_req_val, mem_req_addr, mem_req_opaque, mem_resp_rdy,
           d_val, d_inst, d_pc, err,
    input  mem_req_rdy, mem_resp_val, mem_resp_opaque, mem_resp_data,
           d_rdy, squash, branch_target
  );

  modport slave (
    input  mem_req_val, mem_req_addr, mem_req_opaque, mem_resp_rdy,
           d_val, d_inst, d_pc, err,
    output mem_req_rdy, mem_resp_val, mem_resp_opaque, mem_resp_data,
           d_rdy, squash, branch_target
  );
endinterface

// File: rtl/fetch_rob.sv
// Purpose: sequential instruction fetch with a circular slot buffer; memory
//          responses may return out of order, decode sees them in program order.
// Ports:   clk, rst (sync, active-high); bus = fetch_rob_if.master carrying the
//          memory request/response, decode handshake, squash redirect and err.
//          Latency: memory latency + 1 cycle. Requests stall when all slots are
//          in use; a stalled decode (d_rdy=0) eventually fills every slot.
module fetch_rob #(
  parameter logic [31:0] P_RST_ADDR  = 32'h0,
  parameter int          P_ADDR_BITS = 32,
  parameter int          P_INST_BITS = 32,
  parameter int          P_OPAQ_BITS = 8,
  parameter int          P_DEPTH     = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_rob_if.master  bus
);
  localparam int W = $clog2(P_DEPTH);

  // Per-slot state
  logic [P_DEPTH-1:0]     r_alloc;
  logic [P_DEPTH-1:0]     r_filled;
  logic [P_DEPTH-1:0]     r_killed;
  logic [P_ADDR_BITS-1:0] r_pc   [P_DEPTH];
  logic [P_INST_BITS-1:0] r_inst [P_DEPTH];

  logic [W-1:0]           r_aptr;
  logic [W-1:0]           r_hptr;
  logic [W:0]             r_count;
  logic [P_ADDR_BITS-1:0] r_pc_next;
  logic                   r_err;

  logic                   w_req_val;
  logic [P_ADDR_BITS-1:0] w_req_addr;
  logic                   w_req_fire;
  logic [W-1:0]           w_resp_idx;
  logic                   w_resp_in_range;
  logic                   w_resp_vld;
  logic                   w_resp_ok;
  logic                   w_head_rdy;
  logic                   w_d_val;
  logic                   w_deliver;
  logic                   w_drain;
  logic                   w_free;

  // P_DEPTH is a power of two, so count < P_DEPTH is just "MSB clear".
  assign w_req_val  = !rst && !r_count[W];
  assign w_req_addr = bus.squash ? bus.branch_target : r_pc_next;
  assign w_req_fire = w_req_val && bus.mem_req_rdy;

  // Opaque values at or beyond P_DEPTH never name a slot; widen by one bit
  // so the compare still works when P_DEPTH == 2**P_OPAQ_BITS.
  assign w_resp_idx      = bus.mem_resp_opaque[W-1:0];
  assign w_resp_in_range = {1'b0, bus.mem_resp_opaque} < (P_OPAQ_BITS+1)'(P_DEPTH);
  assign w_resp_vld      = !rst && bus.mem_resp_val;
  assign w_resp_ok       = w_resp_vld && w_resp_in_range &&
                           r_alloc[w_resp_idx] && !r_filled[w_resp_idx];

  // Head slot leaves either by delivery or, if killed, by a silent drain.
  // An unfilled head blocks, killed or not, so a slot is never reused
  // while its response is still in flight.
  assign w_head_rdy = r_alloc[r_hptr] && r_filled[r_hptr];
  assign w_d_val    = !rst && w_head_rdy && !r_killed[r_hptr] && !bus.squash;
  assign w_deliver  = w_d_val && bus.d_rdy;
  assign w_drain    = !rst && w_head_rdy && r_killed[r_hptr];
  assign w_free     = w_deliver || w_drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc   <= '0;
      r_filled  <= '0;
      r_killed  <= '0;
      r_aptr    <= '0;
      r_hptr    <= '0;
      r_count   <= '0;
      r_pc_next <= P_ADDR_BITS'(P_RST_ADDR);
      r_err     <= 1'b0;
    end else begin
      // Kill everything allocated before this cycle; the slot allocated
      // below in the same cycle (at branch_target) overrides its own bit.
      if (bus.squash) begin
        r_killed <= r_killed | r_alloc;
      end

      if (w_resp_ok) begin
        r_filled[w_resp_idx] <= 1'b1;
        r_inst[w_resp_idx]   <= bus.mem_resp_data;
      end

      if (w_free) begin
        r_alloc[r_hptr] <= 1'b0;
        r_hptr          <= r_hptr + W'(1);
      end

      if (w_req_fire) begin
        r_alloc[r_aptr]  <= 1'b1;
        r_filled[r_aptr] <= 1'b0;
        r_killed[r_aptr] <= 1'b0;
        r_pc[r_aptr]     <= w_req_addr;
        r_aptr           <= r_aptr + W'(1);
        r_pc_next        <= w_req_addr + P_ADDR_BITS'(4);
      end else if (bus.squash) begin
        r_pc_next <= bus.branch_target;
      end

      r_count <= r_count + {{W{1'b0}}, w_req_fire} - {{W{1'b0}}, w_free};

      // Response to a free or already-filled slot is dropped and flagged.
      if (w_resp_vld && !w_resp_ok) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.mem_req_val    = w_req_val;
  assign bus.mem_req_addr   = w_req_addr;
  assign bus.mem_req_opaque = P_OPAQ_BITS'(r_aptr);
  assign bus.mem_resp_rdy   = !rst;
  assign bus.d_val          = w_d_val;
  assign bus.d_inst         = r_inst[r_hptr];
  assign bus.d_pc           = r_pc[r_hptr];
  assign bus.err            = r_err;
endmodule

// File: tb/tb_fetch_rob.sv
module tb_fetch_rob;
  localparam int          A        = 32;
  localparam int          I        = 32;
  localparam int          O        = 8;
  localparam int          D        = 4;
  localparam logic [31:0] RST_ADDR = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_rob_if #(.P_ADDR_BITS(A), .P_INST_BITS(I), .P_OPAQ_BITS(O)) bus();

  fetch_rob #(
    .P_RST_ADDR(RST_ADDR), .P_ADDR_BITS(A), .P_INST_BITS(I),
    .P_OPAQ_BITS(O), .P_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fire   = 0;
  int n_deliv  = 0;

  int cfg_req  = 0;
  int cfg_rdy  = 0;
  int cfg_resp = 0;
  int cfg_sq   = 0;
  int cfg_ino  = 1;
  int force_opq = -1;
  logic        force_sq = 1'b0;
  logic [31:0] force_tgt = 32'h0;

  // Reference model: program-order list of instructions decode must see,
  // plus the memory's list of outstanding reads.
  exp_t        exp_q[$];
  logic [7:0]  oq_opq[$];
  logic [31:0] oq_addr[$];
  logic [31:0] model_pc = RST_ADDR;
  logic [31:0] m_ea;
  exp_t        m_e;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h7F4A7C15;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Request-side model: predicts each fetch address and the instruction
  // decode should eventually receive for it; squash discards all pending.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      oq_opq.delete();
      oq_addr.delete();
      model_pc = RST_ADDR;
      chk("rst_req_val", 32'(bus.mem_req_val), 32'd0);
      chk("rst_d_val", 32'(bus.d_val), 32'd0);
      chk("rst_resp_rdy", 32'(bus.mem_resp_rdy), 32'd0);
    end else begin
      if (bus.squash) begin
        chk("squash_no_dval", 32'(bus.d_val), 32'd0);
        exp_q.delete();
      end
      if (bus.mem_req_val && bus.mem_req_rdy) begin
        m_ea = bus.squash ? bus.branch_target : model_pc;
        chk("req_addr", bus.mem_req_addr, m_ea);
        exp_q.push_back('{m_ea, memf(m_ea)});
        model_pc = m_ea + 32'd4;
        n_fire++;
        oq_opq.push_back(bus.mem_req_opaque);
        oq_addr.push_back(bus.mem_req_addr);
      end else if (bus.squash) begin
        model_pc = bus.branch_target;
      end
    end
  end

  // Delivery monitor: every decode transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.d_val && bus.d_rdy) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL d_unexpected actual pc=%h required=no transfer t=%0t", bus.d_pc, $time);
      end else begin
        m_e = exp_q.pop_front();
        chk("d_pc", bus.d_pc, m_e.pc);
        chk("d_inst", bus.d_inst, m_e.inst);
      end
    end
  end

  task automatic tick();
    int k;
    bus.mem_req_rdy = ($urandom_range(99) < 32'(cfg_req));
    bus.d_rdy       = ($urandom_range(99) < 32'(cfg_rdy));
    if (force_sq) begin
      bus.squash        = 1'b1;
      bus.branch_target = force_tgt;
      force_sq          = 1'b0;
    end else begin
      bus.squash        = ($urandom_range(99) < 32'(cfg_sq));
      bus.branch_target = {20'h0, 10'($urandom_range(1023)), 2'b00};
    end
    bus.mem_resp_val    = 1'b0;
    bus.mem_resp_opaque = '0;
    bus.mem_resp_data   = '0;
    if (force_opq >= 0) begin
      bus.mem_resp_val    = 1'b1;
      bus.mem_resp_opaque = 8'(force_opq);
      for (int j = 0; j < oq_opq.size(); j++) begin
        if (oq_opq[j] == 8'(force_opq)) begin
          bus.mem_resp_data = memf(oq_addr[j]);
          oq_opq.delete(j);
          oq_addr.delete(j);
          break;
        end
      end
      force_opq = -1;
    end else if (oq_opq.size() > 0 && $urandom_range(99) < 32'(cfg_resp)) begin
      k = (cfg_ino != 0) ? 0 : int'($urandom_range(oq_opq.size() - 1));
      bus.mem_resp_val    = 1'b1;
      bus.mem_resp_opaque = oq_opq[k];
      bus.mem_resp_data   = memf(oq_addr[k]);
      oq_opq.delete(k);
      oq_addr.delete(k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int rq, input int rd, input int rs, input int sq, input int ino);
    cfg_req = rq; cfg_rdy = rd; cfg_resp = rs; cfg_sq = sq; cfg_ino = ino;
  endtask

  task automatic do_reset();
    set_cfg(0, 0, 0, 0, 1);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    set_cfg(0, 100, 100, 0, cfg_ino);
    while ((exp_q.size() != 0 || oq_opq.size() != 0) && t < 300) begin
      tick();
      t++;
    end
    repeat (2 * D + 2) tick();
    chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_mem_idle", 32'(oq_opq.size()), 32'd0);
    chk("drain_d_val", 32'(bus.d_val), 32'd0);
    chk("drain_req_val", 32'(bus.mem_req_val), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_req_rdy = 1'b0; bus.mem_resp_val = 1'b0; bus.mem_resp_opaque = '0;
    bus.mem_resp_data = '0; bus.d_rdy = 1'b0; bus.squash = 1'b0; bus.branch_target = '0;
    repeat (3) tick();
    chk("rst_err_init", 32'(bus.err), 32'd0);
    rst = 1'b0;

    // 1-cycle in-order memory, decode always ready: one instruction per cycle.
    set_cfg(100, 100, 100, 0, 1);
    n_deliv = 0;
    repeat (40) tick();
    chk("inorder_throughput", 32'(n_deliv >= 34), 32'd1);
    drain();

    // Decode stalled: exactly D requests, then fetch stops until decode drains.
    do_reset();
    set_cfg(100, 0, 100, 0, 1);
    n_fire = 0;
    repeat (12) tick();
    chk("stall_fires", 32'(n_fire), 32'(D));
    chk("stall_req_val", 32'(bus.mem_req_val), 32'd0);
    chk("stall_resp_rdy", 32'(bus.mem_resp_rdy), 32'd1);
    cfg_rdy = 100;
    repeat (12) tick();
    drain();

    // Responses in opaque order 2,0,1: nothing delivered until slot 0 fills.
    do_reset();
    set_cfg(100, 100, 0, 0, 1);
    repeat (3) tick();
    cfg_req = 0;
    tick();
    force_opq = 2;
    tick();
    tick();
    chk("ooo_no_dval", 32'(bus.d_val), 32'd0);
    force_opq = 0;
    tick();
    chk("ooo_head_dval", 32'(bus.d_val), 32'd1);
    chk("ooo_head_pc", bus.d_pc, RST_ADDR);
    force_opq = 1;
    drain();

    // Three outstanding, then redirect to 0x100; stale responses are drained.
    do_reset();
    set_cfg(100, 100, 0, 0, 0);
    repeat (3) tick();
    force_sq  = 1'b1;
    force_tgt = 32'h100;
    tick();
    cfg_resp = 100;
    repeat (8) tick();
    drain();

    // Randomized traffic with squashes, stalls, out-of-order memory and a
    // mid-run reset.
    do_reset();
    set_cfg(70, 60, 50, 4, 0);
    n_deliv = 0;
    repeat (1500) tick();
    do_reset();
    set_cfg(70, 60, 50, 4, 0);
    repeat (1500) tick();
    drain();
    chk("random_err", 32'(bus.err), 32'd0);
    chk("random_progress", 32'(n_deliv >= 300), 32'd1);

    // Response to an unallocated slot: sticky err, cleared only by reset.
    force_opq = 1;
    tick();
    tick();
    chk("err_set", 32'(bus.err), 32'd1);
    repeat (3) tick();
    chk("err_sticky", 32'(bus.err), 32'd1);
    do_reset();
    chk("err_cleared", 32'(bus.err), 32'd0);
    set_cfg(100, 100, 100, 0, 1);
    repeat (6) tick();
    drain();
    chk("err_after_restart", 32'(bus.err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
